// File: rtl/mac_arbiter_if.sv
// Bus bundle between two frame requesters, the mac_arbiter and the shared
// MAC datapath / control FSM.
//
// Handshake: a request beat transfers on a rising clk edge where
// reqN_valid & reqN_ready are both high. A requester holds valid, mode, last
// and its operands stable until the beat transfers. Ready depends only on the
// arbiter state, never on valid. The MAC side has no backpressure: mac_valid
// marks one beat per cycle, and mac_valid_out / mac_done are single-cycle
// strobes from the MAC.
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (requesters plus MAC)
interface mac_arbiter_if #(
  parameter int DW = 16
);
  // requester 0
  logic          req0_valid;
  logic          req0_mode;
  logic          req0_last;
  logic [DW-1:0] req0_a;
  logic [DW-1:0] req0_b;
  logic          req0_ready;
  // requester 1
  logic          req1_valid;
  logic          req1_mode;
  logic          req1_last;
  logic [DW-1:0] req1_a;
  logic [DW-1:0] req1_b;
  logic          req1_ready;
  // shared MAC control/operands
  logic          mac_mode;
  logic          mac_valid;
  logic          mac_last;
  logic [DW-1:0] mac_a;
  logic [DW-1:0] mac_b;
  // MAC result strobes and their routed copies
  logic          mac_valid_out;
  logic          mac_done;
  logic          res0_valid;
  logic          res0_done;
  logic          res1_valid;
  logic          res1_done;
  // status
  logic          owner;
  logic          busy;

  modport slave (
    input  req0_valid, req0_mode, req0_last, req0_a, req0_b,
    input  req1_valid, req1_mode, req1_last, req1_a, req1_b,
    input  mac_valid_out, mac_done,
    output req0_ready, req1_ready,
    output mac_mode, mac_valid, mac_last, mac_a, mac_b,
    output res0_valid, res0_done, res1_valid, res1_done,
    output owner, busy
  );

  modport master (
    output req0_valid, req0_mode, req0_last, req0_a, req0_b,
    output req1_valid, req1_mode, req1_last, req1_a, req1_b,
    output mac_valid_out, mac_done,
    input  req0_ready, req1_ready,
    input  mac_mode, mac_valid, mac_last, mac_a, mac_b,
    input  res0_valid, res0_done, res1_valid, res1_done,
    input  owner, busy
  );
endinterface

// File: rtl/mac_arbiter.sv
// mac_arbiter: frame-level arbiter sharing one MAC datapath between two
// requesters. A grant covers a whole frame up to the requester's last beat.
// The MAC mode is captured at grant and held. After the last beat the block
// sits in DRAIN for DRAIN_CYC cycles so the MAC pipeline empties before the
// next grant. MAC result strobes are steered back to the current owner.
//
// Optional feature macro: MAC_ARB_FIXED_PRIO_EN
//   undefined (default): ties in IDLE are resolved round-robin
//   defined            : req0 always wins a tie (req1 may starve)
module mac_arbiter #(
  parameter int DW        = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  mac_arbiter_if.slave      bus,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  localparam int            CW         = $clog2(DRAIN_CYC + 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYC);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t          state_q, state_d;
  logic            owner_q, owner_d;
  logic            mode_q, mode_d;
  logic            mac_valid_q, mac_valid_d;
  logic            mac_last_q, mac_last_d;
  logic [DW-1:0]   mac_a_q, mac_a_d;
  logic [DW-1:0]   mac_b_q, mac_b_d;
  logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
`ifndef MAC_ARB_FIXED_PRIO_EN
  logic            last_owner_q, last_owner_d;
`endif

  // Per-state handshake decode shared by next-state and output logic.
  logic          ready0, ready1;
  logic          beat0, beat1;
  logic          any_req;
  logic          grant1;
  logic          sel_last;
  logic [DW-1:0] sel_a, sel_b;

  // Ready comes straight from the state; only the owner ever sees ready.
  always_comb begin
    ready0 = (state_q == ST_GRANT0);
    ready1 = (state_q == ST_GRANT1);
    beat0  = ready0 & bus.req0_valid;
    beat1  = ready1 & bus.req1_valid;
  end

  // Pick the winner in IDLE: single requester wins outright, ties go to the
  // requester that did not own the previous frame (or always req0).
  always_comb begin
    any_req = bus.req0_valid | bus.req1_valid;
`ifdef MAC_ARB_FIXED_PRIO_EN
    grant1 = ~bus.req0_valid;
`else
    if (bus.req0_valid && bus.req1_valid) begin
      grant1 = ~last_owner_q;
    end else begin
      grant1 = bus.req1_valid;
    end
`endif
  end

  // Operand/last mux from whichever requester holds the grant.
  always_comb begin
    if (ready1) begin
      sel_a    = bus.req1_a;
      sel_b    = bus.req1_b;
      sel_last = bus.req1_last;
    end else begin
      sel_a    = bus.req0_a;
      sel_b    = bus.req0_b;
      sel_last = bus.req0_last;
    end
  end

  // Next-state and next-output computation for the arbiter FSM.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mode_d      = mode_q;
    mac_valid_d = 1'b0;
    mac_last_d  = 1'b0;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    drain_cnt_d = drain_cnt_q;
`ifndef MAC_ARB_FIXED_PRIO_EN
    last_owner_d = last_owner_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = grant1 ? ST_GRANT1 : ST_GRANT0;
          owner_d = grant1;
          // Mode is sampled only here so the MAC sees it a cycle before the
          // first beat and it cannot change mid-frame.
          mode_d  = grant1 ? bus.req1_mode : bus.req0_mode;
`ifndef MAC_ARB_FIXED_PRIO_EN
          last_owner_d = grant1;
`endif
        end
      end

      ST_GRANT0, ST_GRANT1: begin
        // A missing beat simply becomes a bubble; the grant is kept.
        if (beat0 || beat1) begin
          mac_valid_d = 1'b1;
          mac_last_d  = sel_last;
          mac_a_d     = sel_a;
          mac_b_d     = sel_b;
          if (sel_last) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end
        end
      end

      ST_DRAIN: begin
        drain_cnt_d = drain_cnt_q - CNT_ONE;
        if (drain_cnt_q == CNT_ONE) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and all registered outputs; async active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      mode_q      <= 1'b0;
      mac_valid_q <= 1'b0;
      mac_last_q  <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      drain_cnt_q <= '0;
`ifndef MAC_ARB_FIXED_PRIO_EN
      // req0 wins the first tie after reset.
      last_owner_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mode_q      <= mode_d;
      mac_valid_q <= mac_valid_d;
      mac_last_q  <= mac_last_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      drain_cnt_q <= drain_cnt_d;
`ifndef MAC_ARB_FIXED_PRIO_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Outputs: registered values plus combinational ready/busy/result routing.
  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.mac_mode   = mode_q;
  assign bus.mac_valid  = mac_valid_q;
  assign bus.mac_last   = mac_last_q;
  assign bus.mac_a      = mac_a_q;
  assign bus.mac_b      = mac_b_q;
  assign bus.owner      = owner_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.res0_valid = bus.mac_valid_out & ~owner_q;
  assign bus.res0_done  = bus.mac_done      & ~owner_q;
  assign bus.res1_valid = bus.mac_valid_out &  owner_q;
  assign bus.res1_done  = bus.mac_done      &  owner_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_mac_arbiter.sv
// Testbench for mac_arbiter (default build: round-robin tie breaking).
// Per cycle: inputs are driven 1 ns after the rising edge and outputs are
// checked 1 ns later. A table gives inputs and expected ready/mode/owner/
// busy/result routing for each cycle; MAC beats are checked through an
// expected queue fed whenever the bench drives a beat that should be taken.
module tb_mac_arbiter;
  localparam int DW = 16;
  localparam int NV = 34;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0] state_dbg;
  mac_arbiter_if #(.DW(DW)) bus ();

  mac_arbiter #(.DW(DW), .DRAIN_CYC(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  typedef struct {
    logic          v0, m0, l0;
    logic [DW-1:0] a0, b0;
    logic          v1, m1, l1;
    logic [DW-1:0] a1, b1;
    logic          mvo, mdn;
    logic          rdy0, rdy1, mode, own, busy, r0v, r0d, r1v, r1d;
  } vec_t;

  vec_t vt[NV];
  logic [2*DW+1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(inout vec_t v, input logic v0, m0, l0, input int a0, b0,
                        input logic v1, m1, l1, input int a1, b1, input logic mvo, mdn);
    v.v0 = v0; v.m0 = m0; v.l0 = l0; v.a0 = DW'(a0); v.b0 = DW'(b0);
    v.v1 = v1; v.m1 = m1; v.l1 = l1; v.a1 = DW'(a1); v.b1 = DW'(b1);
    v.mvo = mvo; v.mdn = mdn;
  endtask

  task automatic set_ex(inout vec_t v, input logic rdy0, rdy1, mode, own, busy,
                        input logic r0v, r0d, r1v, r1d);
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.mode = mode; v.own = own; v.busy = busy;
    v.r0v = r0v; v.r0d = r0d; v.r1v = r1v; v.r1d = r1d;
  endtask

  // driver
  task automatic drive(input vec_t v);
    bus.req0_valid = v.v0; bus.req0_mode = v.m0; bus.req0_last = v.l0;
    bus.req0_a = v.a0; bus.req0_b = v.b0;
    bus.req1_valid = v.v1; bus.req1_mode = v.m1; bus.req1_last = v.l1;
    bus.req1_a = v.a1; bus.req1_b = v.b1;
    bus.mac_valid_out = v.mvo; bus.mac_done = v.mdn;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rdy0"},  32'(bus.req0_ready), 0);
    chk({tag, ".rdy1"},  32'(bus.req1_ready), 0);
    chk({tag, ".mode"},  32'(bus.mac_mode), 0);
    chk({tag, ".mvld"},  32'(bus.mac_valid), 0);
    chk({tag, ".mlast"}, 32'(bus.mac_last), 0);
    chk({tag, ".ma"},    32'(bus.mac_a), 0);
    chk({tag, ".mb"},    32'(bus.mac_b), 0);
    chk({tag, ".owner"}, 32'(bus.owner), 0);
    chk({tag, ".busy"},  32'(bus.busy), 0);
    chk({tag, ".res"},   32'({bus.res0_valid, bus.res0_done, bus.res1_valid, bus.res1_done}), 0);
    chk({tag, ".state"}, 32'(state_dbg), 0);
  endtask

  // One cycle: drive, check against the record, update the scoreboard.
  task automatic apply(input vec_t v, input string tag);
    logic [2*DW+1:0] e;
    @(posedge clk);
    #1;
    drive(v);
    #1;
    chk({tag, ".rdy0"},  32'(bus.req0_ready), 32'(v.rdy0));
    chk({tag, ".rdy1"},  32'(bus.req1_ready), 32'(v.rdy1));
    chk({tag, ".mode"},  32'(bus.mac_mode),   32'(v.mode));
    chk({tag, ".owner"}, 32'(bus.owner),      32'(v.own));
    chk({tag, ".busy"},  32'(bus.busy),       32'(v.busy));
    chk({tag, ".r0v"},   32'(bus.res0_valid), 32'(v.r0v));
    chk({tag, ".r0d"},   32'(bus.res0_done),  32'(v.r0d));
    chk({tag, ".r1v"},   32'(bus.res1_valid), 32'(v.r1v));
    chk({tag, ".r1d"},   32'(bus.res1_done),  32'(v.r1d));
    if (exp_q.size() == 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s.sb: expected queue empty, mac_valid=%0b", tag, bus.mac_valid);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk({tag, ".mvld"},  32'(bus.mac_valid), 32'(e[2*DW+1]));
    chk({tag, ".mlast"}, 32'(bus.mac_last),  32'(e[2*DW]));
    if (e[2*DW+1]) begin
      chk({tag, ".ma"}, 32'(bus.mac_a), 32'(e[2*DW-1:DW]));
      chk({tag, ".mb"}, 32'(bus.mac_b), 32'(e[DW-1:0]));
    end
    if (v.v0 && v.rdy0)      exp_q.push_back({1'b1, v.l0, v.a0, v.b0});
    else if (v.v1 && v.rdy1) exp_q.push_back({1'b1, v.l1, v.a1, v.b1});
    else                     exp_q.push_back('0);
  endtask

  initial begin
    vec_t r;
    r = '{default: '0};
    foreach (vt[i]) vt[i] = '{default: '0};

    //        v0 m0 l0 a0 b0  v1 m1 l1 a1 b1 mvo mdn      rdy0 rdy1 mode own busy r0v r0d r1v r1d
    // req0: 4-beat mode-0 frame, a=1..4, b=2
    set_in(vt[0],  1,0,0, 1,2,  0,0,0, 0,0,  0,0); set_ex(vt[0],  0,0,0,0,0, 0,0,0,0);
    set_in(vt[1],  1,0,0, 1,2,  0,0,0, 0,0,  0,0); set_ex(vt[1],  1,0,0,0,1, 0,0,0,0);
    set_in(vt[2],  1,0,0, 2,2,  0,0,0, 0,0,  0,0); set_ex(vt[2],  1,0,0,0,1, 0,0,0,0);
    set_in(vt[3],  1,0,0, 3,2,  0,0,0, 0,0,  0,0); set_ex(vt[3],  1,0,0,0,1, 0,0,0,0);
    set_in(vt[4],  1,0,1, 4,2,  0,0,0, 0,0,  0,0); set_ex(vt[4],  1,0,0,0,1, 0,0,0,0);
    set_in(vt[5],  0,0,0, 0,0,  0,0,0, 0,0,  1,0); set_ex(vt[5],  0,0,0,0,1, 1,0,0,0);
    set_in(vt[6],  0,0,0, 0,0,  0,0,0, 0,0,  1,1); set_ex(vt[6],  0,0,0,0,1, 1,1,0,0);
    set_in(vt[7],  0,0,0, 0,0,  0,0,0, 0,0,  0,0); set_ex(vt[7],  0,0,0,0,1, 0,0,0,0);
    // req1: mode-1 3-beat frame with 2-cycle bubble; req0 pushes meanwhile
    set_in(vt[8],  0,0,0, 0,0,  1,1,0,10,20, 0,0); set_ex(vt[8],  0,0,0,0,0, 0,0,0,0);
    set_in(vt[9],  0,0,0, 0,0,  1,0,0,10,20, 0,0); set_ex(vt[9],  0,1,1,1,1, 0,0,0,0);
    set_in(vt[10], 1,1,1,99,99, 0,0,0, 0,0,  0,0); set_ex(vt[10], 0,1,1,1,1, 0,0,0,0);
    set_in(vt[11], 1,1,1,99,99, 0,0,0, 0,0,  0,0); set_ex(vt[11], 0,1,1,1,1, 0,0,0,0);
    set_in(vt[12], 1,1,1,99,99, 1,0,0,11,21, 0,0); set_ex(vt[12], 0,1,1,1,1, 0,0,0,0);
    set_in(vt[13], 0,0,0, 0,0,  1,0,1,12,22, 0,0); set_ex(vt[13], 0,1,1,1,1, 0,0,0,0);
    set_in(vt[14], 0,0,0, 0,0,  0,0,0, 0,0,  1,0); set_ex(vt[14], 0,0,1,1,1, 0,0,1,0);
    set_in(vt[15], 0,0,0, 0,0,  0,0,0, 0,0,  1,1); set_ex(vt[15], 0,0,1,1,1, 0,0,1,1);
    set_in(vt[16], 0,0,0, 0,0,  0,0,0, 0,0,  0,0); set_ex(vt[16], 0,0,1,1,1, 0,0,0,0);
    // tie: req0 wins (owned by req1 last), req0 toggles mode mid-frame
    set_in(vt[17], 1,1,0, 5,6,  1,0,1, 7,8,  0,0); set_ex(vt[17], 0,0,1,1,0, 0,0,0,0);
    set_in(vt[18], 1,0,0, 5,6,  1,0,1, 7,8,  0,0); set_ex(vt[18], 1,0,1,0,1, 0,0,0,0);
    set_in(vt[19], 1,0,1, 9,3,  1,0,1, 7,8,  0,0); set_ex(vt[19], 1,0,1,0,1, 0,0,0,0);
    set_in(vt[20], 0,0,0, 0,0,  1,0,1, 7,8,  0,0); set_ex(vt[20], 0,0,1,0,1, 0,0,0,0);
    set_in(vt[21], 0,0,0, 0,0,  1,0,1, 7,8,  0,0); set_ex(vt[21], 0,0,1,0,1, 0,0,0,0);
    set_in(vt[22], 0,0,0, 0,0,  1,0,1, 7,8,  0,0); set_ex(vt[22], 0,0,1,0,1, 0,0,0,0);
    // tie again: req1 wins this time; req1 single-beat frame
    set_in(vt[23], 1,0,1,13,14, 1,0,1, 7,8,  0,0); set_ex(vt[23], 0,0,1,0,0, 0,0,0,0);
    set_in(vt[24], 1,0,1,13,14, 1,0,1, 7,8,  0,0); set_ex(vt[24], 0,1,0,1,1, 0,0,0,0);
    set_in(vt[25], 1,0,1,13,14, 0,0,0, 0,0,  0,0); set_ex(vt[25], 0,0,0,1,1, 0,0,0,0);
    set_in(vt[26], 1,0,1,13,14, 0,0,0, 0,0,  1,1); set_ex(vt[26], 0,0,0,1,1, 0,0,1,1);
    set_in(vt[27], 1,0,1,13,14, 0,0,0, 0,0,  0,0); set_ex(vt[27], 0,0,0,1,1, 0,0,0,0);
    // req0 single-beat frame, mode flips after grant and is ignored
    set_in(vt[28], 1,0,1,13,14, 0,0,0, 0,0,  0,0); set_ex(vt[28], 0,0,0,1,0, 0,0,0,0);
    set_in(vt[29], 1,1,1,13,14, 0,0,0, 0,0,  0,0); set_ex(vt[29], 1,0,0,0,1, 0,0,0,0);
    set_in(vt[30], 0,1,0, 0,0,  0,0,0, 0,0,  0,0); set_ex(vt[30], 0,0,0,0,1, 0,0,0,0);
    set_in(vt[31], 0,1,0, 0,0,  0,0,0, 0,0,  1,0); set_ex(vt[31], 0,0,0,0,1, 1,0,0,0);
    set_in(vt[32], 0,0,0, 0,0,  0,0,0, 0,0,  0,0); set_ex(vt[32], 0,0,0,0,1, 0,0,0,0);
    set_in(vt[33], 0,0,0, 0,0,  0,0,0, 0,0,  0,0); set_ex(vt[33], 0,0,0,0,0, 0,0,0,0);

    // reset
    reset = 1'b1;
    drive(r);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;
    exp_q.push_back('0);

    // table
    for (int i = 0; i < NV; i++) begin
      apply(vt[i], $sformatf("vec%0d", i));
    end

    // reset mid-frame in GRANT1 after two beats
    set_in(r, 0,0,0, 0,0, 1,1,0,30,31, 0,0); set_ex(r, 0,0,0,0,0, 0,0,0,0);
    apply(r, "rst_s0");
    set_in(r, 0,0,0, 0,0, 1,1,0,30,31, 0,0); set_ex(r, 0,1,1,1,1, 0,0,0,0);
    apply(r, "rst_s1");
    set_in(r, 0,0,0, 0,0, 1,1,0,32,33, 0,0); set_ex(r, 0,1,1,1,1, 0,0,0,0);
    apply(r, "rst_s2");
    @(posedge clk);
    #1;
    chk("rst_pre.mode",  32'(bus.mac_mode), 1);
    chk("rst_pre.owner", 32'(bus.owner), 1);
    chk("rst_pre.ma",    32'(bus.mac_a), 32);
    chk("rst_pre.state", 32'(state_dbg), 2);
    reset = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_q.push_back('0);
    set_in(r, 1,1,1,40,41, 1,0,1,50,51, 0,0);
    drive(r);

    // first tie after reset goes to req0, then req1
    set_ex(r, 1,0,1,0,1, 0,0,0,0); apply(r, "tie_t1");
    set_in(r, 0,0,0, 0,0, 1,0,1,50,51, 0,0);
    set_ex(r, 0,0,1,0,1, 0,0,0,0); apply(r, "tie_t2");
    apply(r, "tie_t3");
    apply(r, "tie_t4");
    set_ex(r, 0,0,1,0,0, 0,0,0,0); apply(r, "tie_t5");
    set_ex(r, 0,1,0,1,1, 0,0,0,0); apply(r, "tie_t6");
    set_in(r, 0,0,0, 0,0, 0,0,0, 0,0, 1,0);
    set_ex(r, 0,0,0,1,1, 0,0,1,0); apply(r, "tie_t7");
    set_in(r, 0,0,0, 0,0, 0,0,0, 0,0, 0,0);
    set_ex(r, 0,0,0,1,1, 0,0,0,0); apply(r, "tie_t8");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mac_arbiter.md
# mac_arbiter

Frame-level arbiter that shares one quadratic-equation MAC datapath and its mode/valid/last control FSM between two independent requesters. It grants the MAC to one requester for a whole frame, ending on that requester's `last` beat. It holds the MAC mode constant for the frame and drains the pipeline before re-arbitrating. MAC result strobes are routed back to the owning requester.

## Interface
- `DW`, 16, operand width of `a`/`b`
- `DRAIN_CYC`, 3, cycles spent in DRAIN after the last beat (≥3; covers MAC valid_out/done latency plus this block's output register)
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req0_valid`, `req1_valid`  in  1  beat offered
- `req0_mode`, `req1_mode`  in  1  requested MAC mode (0 = per-sample, 1 = accumulate); sampled at grant only
- `req0_last`, `req1_last`  in  1  final beat of frame
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  DW  operands
- `req0_ready`, `req1_ready`  out  1  beat accepted when valid & ready
- `mac_mode`  out  1  MAC mode, registered
- `mac_valid`, `mac_last`  out  1  to MAC FSM valid_in / last_in, registered
- `mac_a`, `mac_b`  out  DW  registered operands
- `mac_valid_out`, `mac_done`  in  1  MAC result strobes
- `res0_valid`, `res0_done`, `res1_valid`, `res1_done`  out  1  routed result strobes
- `owner`  out  1  requester currently or last granted
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, GRANT0, GRANT1, DRAIN. State is registered.
- IDLE, no `reqN_valid`: stay in IDLE.
- IDLE, exactly one valid: next state GRANTn. `owner <= n`. `mac_mode <= reqn_mode`.
- IDLE, both valid: round-robin. Grant goes to `!last_owner`. `last_owner <= granted`.
- GRANTn: `reqn_ready = 1` (combinational from state). The other ready is 0.
- Accepted beat: `mac_valid <= 1`, `mac_a/b <= reqn_a/b`, `mac_last <= reqn_last`.
- No beat in a cycle: `mac_valid <= 0`, `mac_last <= 0`. The bubble is passed through and the grant is held.
- Accepted beat with `last = 1`: next state DRAIN. Drain counter `<= DRAIN_CYC`.
- A single-beat frame (valid & last on the first beat) is legal.
- DRAIN: `mac_valid = mac_last = 0`. Counter decrements every cycle. At counter == 1, next state is IDLE, so DRAIN lasts exactly DRAIN_CYC cycles.
- `mac_mode` and `owner` hold from grant through DRAIN and IDLE, changing only at the next grant. `reqn_mode` is ignored after grant.
- `resN_valid = mac_valid_out & (owner == N)` and `resN_done = mac_done & (owner == N)`, both combinational.
- Reset mid-frame: the frame is abandoned. All registers return to reset values and the state goes to IDLE. The requester restarts from its first beat.

## Timing
- Reset values: state = IDLE, `owner = 0`, `last_owner = 1` (req0 wins the first tie), `mac_mode = 0`, `mac_valid = 0`, `mac_last = 0`, `mac_a = mac_b = 0`, `busy = 0`, all `ready = 0`, all `res* = 0`.
- Grant latency: a request at IDLE in cycle t gives GRANT state and ready in cycle t+1.
- Beat latency: a beat accepted in cycle t appears on `mac_*` in cycle t+1.
- `mac_mode` changes one cycle before the first `mac_valid` of a frame. This gives the MAC FSM's mode-driven state register one cycle to settle.
- Minimum frame-to-frame gap on the MAC side: DRAIN_CYC + 1 idle cycles between the last `mac_valid` of one frame and the first of the next.
- Result routing latency: none added (combinational).

## Configuration
- `MAC_ARB_FIXED_PRIO_EN` defined: in IDLE with both valid, req0 always wins. `last_owner` is not implemented and req1 may starve.
- `MAC_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.

## Test plan
- Reset, then req0 sends a 4-beat mode-0 frame, a = 1..4, b = 2, last on beat 4.
  - `mac_mode = 0` from cycle t+1.
  - `mac_valid` high in cycles t+2..t+5, `mac_last` only at t+5.
  - DRAIN for 3 cycles, then `busy = 0`.
  - Results appear only on `res0_valid`.
- Both requesters valid in the same IDLE cycle: req0 is granted first, then req1.
  - Repeat: req0 wins again, so grants alternate.
  - With `MAC_ARB_FIXED_PRIO_EN`, req0 wins every tie.
- req1 mode-1 frame of 3 beats with `req1_valid` low for 2 cycles mid-frame:
  - `mac_valid` shows the 2-cycle bubble and the grant is held.
  - `req0_ready` stays 0 throughout.
  - `res1_done` pulses when `mac_done` pulses.
- req0 toggles `req0_mode` mid-frame: `mac_mode` stays at the value sampled at grant until the next frame is granted.
- Assert `reset` while in GRANT1 after 2 beats:
  - All outputs reach reset values immediately.
  - After reset release, the next tie grants req0.
- Single-beat frame (valid & last together) from req1: exactly one `mac_valid` with `mac_last`, then DRAIN for 3 cycles.
